// File: rtl/float_div_cynw_cm_float_rcp_e8_m23_4_tail.sv
// rtl/float_div_cynw_cm_float_rcp_e8_m23_4_tail.sv - E8M23 reciprocal tail: RNE rounding, special packing, output FIFO, upstream stall
module float_div_cynw_cm_float_rcp_e8_m23_4_tail #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             in_valid,
  input  logic [36:0]      x,
  output logic             astall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [PTR_W:0]   out_count
);

  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic             w_sign;
  logic [7:0]       w_exp;
  logic             w_inc;
  logic             w_carry;
  logic [22:0]      w_frac_rnd;
  logic [8:0]       w_exp_rnd;
  logic [31:0]      w_rounded;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  logic             r_valid;
  logic [31:0]      r_data;
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  assign w_sign = x[36];
  assign w_exp  = x[35:28];
  // The round bit is folded into sticky; x[4] breaks ties toward even.
  assign w_inc      = x[3] & (x[2] | x[1] | x[0] | x[4]);
  assign w_frac_rnd = x[26:4] + {22'b0, w_inc};
  assign w_carry    = x[27] & (&x[26:4]) & w_inc;
  assign w_exp_rnd  = {1'b0, w_exp} + {8'b0, w_carry};

  always_comb begin
    w_rounded = {w_sign, w_exp_rnd[7:0], w_frac_rnd};
    if (w_exp == 8'hFF) begin
      if (|x[26:0]) w_rounded = 32'h7FC0_0000;
      else          w_rounded = {w_sign, 8'hFF, 23'b0};
    end else if (w_exp == 8'h00) begin
      w_rounded = {w_sign, 31'b0};
    end else if (w_exp_rnd == 9'h0FF) begin
      w_rounded = {w_sign, 8'hFF, 23'b0};
    end
  end

  assign w_full    = (r_count == C_DEPTH);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_valid & (~w_full | w_pop);
  // Only combinational path from out_ready: a full FIFO draining this cycle frees R.
  assign astall    = r_valid & w_full & ~out_ready;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_count = r_count;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!astall) begin
      r_valid <= in_valid;
      r_data  <= w_rounded;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_cynw_cm_float_rcp_e8_m23_4_tail.sv
// tb/tb_float_div_cynw_cm_float_rcp_e8_m23_4_tail.sv - self-checking bench for the reciprocal tail
module tb_float_div_cynw_cm_float_rcp_e8_m23_4_tail;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic [36:0] x;
  logic        astall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data = '0;

  float_div_cynw_cm_float_rcp_e8_m23_4_tail #(.DEPTH(4), .PTR_W(2)) dut (
    .aclk(aclk), .arst_n(arst_n), .in_valid(in_valid), .x(x), .astall(astall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_rcp(input logic [36:0] xv);
    int unsigned e, m, low;
    logic s;
    s   = xv[36];
    e   = 32'(xv[35:28]);
    m   = 32'(xv[27:4]);
    low = 32'(xv[3:0]);
    if (e == 255) return (xv[26:0] != 0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'h0};
    if (e == 0) return {s, 31'h0};
    if (low > 8 || (low == 8 && (m % 2) == 1)) m++;
    if (m >= 32'h0100_0000) begin
      e++;
      m = 0;
    end
    if (e == 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [36:0] rand_x();
    logic [7:0]  e;
    logic [27:0] m;
    case ($urandom % 8)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'hFE;
      default: e = 8'($urandom);
    endcase
    m = 28'($urandom);
    if ($urandom % 4 == 0) m[27:4] = '1;
    if (e == 8'hFF && ($urandom % 2) == 1) m = '0;
    return {1'($urandom), e, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: apply inputs in the low phase, then score what the DUT shows for that cycle.
  task automatic drive(input logic v, input logic [36:0] xx, input logic rdy);
    @(negedge aclk);
    in_valid  = v;
    x         = xx;
    out_ready = rdy;
    #1;
    if (hold_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
    end
    if (in_valid && !astall) q.push_back(ref_rcp(x));
    if (out_valid && out_ready) begin
      check("token_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) check("order_data", out_data, q.pop_front());
    end
    hold_prev = out_valid && !out_ready;
    prev_data = out_data;
  endtask

  task automatic one_token(input logic [36:0] xx, input logic [31:0] expv, input string tag);
    drive(1'b1, xx, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, out_data, expv);
  endtask

  initial begin
    logic [36:0] tk[6];
    logic [36:0] xr;
    logic        vr;
    logic        rdy;

    arst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_astall", 32'(astall), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(negedge aclk);
    arst_n = 1'b1;

    drive(1'b1, 37'h07E8000000, 1'b1);
    check("basic_lat0", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("basic_lat1", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", out_data, 32'h3F00_0000);
    drive(1'b0, '0, 1'b1);
    check("basic_one_cycle", 32'(out_valid), 32'd0);

    one_token(37'h07EFFFFFF8, 32'h3F80_0000, "rnd_carry");
    one_token(37'h07E8000008, 32'h3F00_0000, "rnd_tie_even");
    one_token(37'h07E8000018, 32'h3F00_0002, "rnd_tie_odd");
    one_token(37'h0FEFFFFFF8, 32'h7F80_0000, "ovf_inf");
    one_token(37'h0FF0000010, 32'h7FC0_0000, "nan_pos");
    one_token(37'h1FF0000008, 32'h7FC0_0000, "nan_neg_grs");
    one_token(37'h1FF0000000, 32'hFF80_0000, "inf_neg");
    one_token(37'h1001234567, 32'h8000_0000, "ftz_neg");
    one_token(37'h17F8000000, 32'hBF80_0000, "neg_one");

    for (int i = 0; i < 6; i++) tk[i] = rand_x();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tk[i], 1'b0);
      check("bp_fill_astall", 32'(astall), 32'd0);
    end
    drive(1'b1, tk[5], 1'b0);
    check("bp_astall", 32'(astall), 32'd1);
    check("bp_full", 32'(out_count), 32'd4);
    drive(1'b1, tk[5], 1'b0);
    check("bp_astall_hold", 32'(astall), 32'd1);
    drive(1'b1, tk[5], 1'b1);
    check("bp_release_same_cycle", 32'(astall), 32'd0);
    check("bp_release_count", 32'(out_count), 32'd4);
    drive(1'b0, '0, 1'b0);
    check("sim_full_count", 32'(out_count), 32'd4);
    check("sim_full_astall", 32'(astall), 32'd1);
    drive(1'b0, '0, 1'b1);
    check("sim_pushpop_astall", 32'(astall), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("sim_pushpop_count", 32'(out_count), 32'd4);
    for (int i = 0; i < 40 && q.size() != 0; i++) drive(1'b0, '0, 1'b1);
    check("bp_drained", 32'(q.size()), 32'd0);

    drive(1'b1, 37'h07E8000018, 1'b0);
    drive(1'b1, 37'h0FEFFFFFF8, 1'b0);
    drive(1'b1, 37'h1001234567, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("pre_rst_count", 32'(out_count), 32'd3);
    arst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_astall", 32'(astall), 32'd0);
    check("async_rst_count", 32'(out_count), 32'd0);
    q.delete();
    hold_prev = 1'b0;
    @(negedge aclk);
    arst_n = 1'b1;
    drive(1'b1, 37'h07EFFFFFF8, 1'b1);
    check("post_rst_lat0", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("post_rst_lat1", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", out_data, 32'h3F80_0000);

    xr = '0;
    vr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && astall)) begin
        vr = ($urandom % 4) != 0;
        xr = rand_x();
      end
      rdy = ((c % 200) < 100) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      drive(vr, xr, rdy);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) drive(1'b0, '0, 1'b1);
    check("rand_drained", 32'(q.size()), 32'd0);
    drive(1'b0, '0, 1'b1);
    check("rand_final_count", 32'(out_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/float_div_cynw_cm_float_rcp_e8_m23_4_tail.md
Name: float_div_cynw_cm_float_rcp_E8_M23_4_tail

Overview:
Back end of the 4-stage E8M23 reciprocal pipe. It consumes the 37-bit unrounded intermediate `x` produced by the stalled front stages. It performs round-to-nearest-even and special-case packing into IEEE single, then buffers results in a small FIFO with a ready/valid output. It is the sole source of `astall`, which freezes every upstream pipe register when the tail cannot accept data.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
aclk  input  1  clock, all state on rising edge
arst_n  input  1  asynchronous active-low reset
in_valid  input  1  `x` carries a live token (travels with pipe, held while astall=1)
x  input  37  intermediate: [36] sign, [35:8-aligned 35:28] biased exp, [27] hidden one, [26:4] fraction, [3] guard, [2] round, [1:0] sticky
astall  output  1  stall to upstream rreg enables (enable = ~astall)
out_valid  output  1  `out_data` valid
out_ready  input  1  consumer accepts
out_data  output  32  IEEE-754 single result
out_count  output  PTR_W+1  FIFO occupancy

Behaviour:
- Reset (arst_n=0, async): R_valid=0, FIFO empty, rd/wr pointers 0, out_valid=0, out_data=0, out_count=0, astall=0.
- Stage R (round register, 1 entry):
  - Loads when astall=0: R_valid<=in_valid, R_data<=round(x).
  - While astall=1, R holds and in_valid/x are ignored; upstream holds them stable.
- Rounding:
  - sticky_any = x[2] | x[1] | x[0].
  - inc = x[3] & (sticky_any | x[4]).
  - 24-bit sum {x[27:4]}+inc. If the sum carries out, exp+1 and fraction=0.
- Special cases, evaluated before rounding and in this priority order:
  - exp=0xFF with fraction/GRS nonzero -> 0x7FC00000 (sign ignored).
  - exp=0xFF with all zero -> {sign, 0xFF, 0}.
  - exp=0 -> {sign, 31'b0} (flush to zero).
  - Rounding carry taking exp 0xFE to 0xFF -> {sign, 0xFF, 0} (infinity).
- FIFO:
  - R advances into the FIFO when R_valid & (count<DEPTH | pop).
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- out_valid = (count!=0). out_data = mem[rd_ptr], i.e. show-ahead. Data is stable while out_valid=1 and out_ready=0.
- astall = R_valid & (count==DEPTH) & ~out_ready. This is combinational, and is the only path from out_ready to astall.
- Latency: a token accepted at cycle N (astall=0, in_valid=1) enters R at N+1, is written to the FIFO at the N+1 edge, and appears on out_data at N+2 when the FIFO was empty.
- Throughput is 1/cycle when out_ready stays high.
- No token is lost or duplicated under any stall/ready pattern. Tokens leave in arrival order.
- Reset mid-operation discards R and all FIFO contents; astall deasserts immediately.

Test Plan:
- Basic: x=0x07E8000000, in_valid=1 for 1 cycle, out_ready=1 -> out_data=0x3F000000 two cycles later, out_valid high 1 cycle.
- Rounding: x=0x07EFFFFFF8 -> 0x3F800000 (carry into exp). x=0x07E8000008 (tie, LSB 0) -> 0x3F000000. x=0x07E8000018 (tie, LSB 1) -> 0x3F000002.
- Specials:
  - x={0,0xFE,0xFFFFFF8} -> 0x7F800000.
  - exp=0xFF, frac nonzero -> 0x7FC00000.
  - x={1,0x00,any} -> 0x80000000.
- Backpressure: out_ready=0 while 6 tokens are streamed -> FIFO fills to 4, R holds the 5th, astall=1 while the 6th is held upstream. Raise out_ready -> astall drops the same cycle. All 6 results emerge in order, none lost.
- Simultaneous: FIFO full, R_valid=1, out_ready=1 -> astall=0, push and pop in the same cycle, out_count stays 4.
- Reset: assert arst_n low with FIFO holding 3 tokens -> out_valid, astall and out_count go to 0 without a clock edge. After release, a new token passes with the latency above.
